// File: rtl/ternary_pkg.sv
// Package for the NTRU-HRSS ternary-plus stage.
// Holds the 2-bit ternary coefficient encoding, the polynomial size, the
// FSM state type and small coefficient arithmetic helpers shared by
// ternary_plus and ternary_corr_acc.
package ternary_pkg;

  localparam int N_COEF = 700;

  typedef logic [1:0] coef_t;

  localparam coef_t COEF_ZERO = 2'b00;
  localparam coef_t COEF_POS  = 2'b01;
  localparam coef_t COEF_NEG  = 2'b10;

  typedef enum logic {LOAD, EMIT} state_t;

  // Maps the illegal code 2'b11 onto zero; legal codes pass through.
  function automatic coef_t coef_clean(input coef_t c);
    return (c == 2'b11) ? COEF_ZERO : c;
  endfunction

  // Negation swaps +1 and -1; zero (and the illegal code) become zero.
  function automatic coef_t coef_neg(input coef_t c);
    case (c)
      COEF_POS: return COEF_NEG;
      COEF_NEG: return COEF_POS;
      default:  return COEF_ZERO;
    endcase
  endfunction

  // Signed product of two ternary coefficients, in {-1, 0, +1}.
  function automatic logic signed [1:0] coef_mul(input coef_t a, input coef_t b);
    if ((a == COEF_POS || a == COEF_NEG) && (b == COEF_POS || b == COEF_NEG))
      return (a == b) ? 2'sd1 : -2'sd1;
    return 2'sd0;
  endfunction

endpackage

// File: rtl/ternary_corr_acc.sv
// Correlation accumulator t = sum v[i]*v[i+1] over one polynomial.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           clears prev and t (end of polynomial)
//   en            a coefficient is accepted this cycle
//   coef_in       accepted coefficient (already cleaned of 2'b11)
//   t             current accumulated correlation (signed, TW bits)
//   t_next_neg    sign of t including the product of the coefficient on
//                 coef_in; valid while en is high
module ternary_corr_acc
  import ternary_pkg::*;
#(
  parameter int TW = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  coef_t                coef_in,
  output logic signed [TW-1:0] t,
  output logic                 t_next_neg
);

  coef_t                prev;
  logic signed [1:0]    prod;
  logic signed [TW-1:0] t_next;

  // prev is zero before the first beat, so the first product is zero and
  // no separate "index > 0" qualifier is needed.
  assign prod       = coef_mul(prev, coef_in);
  assign t_next     = t + {{(TW-2){prod[1]}}, prod};
  assign t_next_neg = t_next[TW-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      t    <= '0;
      prev <= COEF_ZERO;
    end else if (en) begin
      t    <= t_next;
      prev <= coef_in;
    end
  end

endmodule

// File: rtl/ternary_plus.sv
// Ternary-plus stage: buffers N ternary coefficients, computes the
// neighbour correlation t, and re-emits the polynomial with every
// even-index coefficient negated when t < 0.
// Optional build macro: TERNARY_PLUS_VEC_OUT_EN adds a parallel copy of
// the corrected polynomial (out_vec) with a one-cycle vec_valid pulse.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input coefficient handshake, in_coef data
//   out_valid/out_ready   output coefficient handshake, out_coef data
//   out_last              marks coefficient index N-1
//   flipped               sign decision of the current/last polynomial
//   busy                  high after the first input beat and while emitting
//   out_vec, vec_valid    (TERNARY_PLUS_VEC_OUT_EN only) parallel result
module ternary_plus
  import ternary_pkg::*;
#(
  parameter int N  = N_COEF,
  parameter int TW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [1:0]     in_coef,
  output logic           in_ready,
  output logic           out_valid,
  output logic [1:0]     out_coef,
  input  logic           out_ready,
  output logic           out_last,
  output logic           flipped,
  output logic           busy
`ifdef TERNARY_PLUS_VEC_OUT_EN
  ,
  output logic [2*N-1:0] out_vec,
  output logic           vec_valid
`endif
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic signed [TW-1:0] T_MAX = TW'(N - 1);

  state_t               state, state_next;
  logic [IW-1:0]        idx;
  coef_t                coef_buf [N];
  coef_t                coef_in_c;
  coef_t                rd_coef;
  logic                 in_fire, out_fire, last_in, last_out;
  logic signed [TW-1:0] corr_t;
  logic                 t_next_neg;

  assign coef_in_c = coef_clean(in_coef);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_in   = in_fire && (idx == IDX_LAST);
  assign last_out  = out_fire && (idx == IDX_LAST);
  assign rd_coef   = coef_buf[idx];
  assign busy      = (state == EMIT) || (idx != '0);

  ternary_corr_acc #(.TW(TW)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr        (last_out),
    .en         (in_fire),
    .coef_in    (coef_in_c),
    .t          (corr_t),
    .t_next_neg (t_next_neg)
  );

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_coef   = COEF_ZERO;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (last_in) state_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (idx == IDX_LAST);
        // Index 0 is even; idx[0] == 0 selects the even positions.
        out_coef  = (flipped && !idx[0]) ? coef_neg(rd_coef) : rd_coef;
        if (last_out) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      idx     <= '0;
      flipped <= 1'b0;
    end else begin
      state <= state_next;
      if (last_in || last_out)
        idx <= '0;
      else if (in_fire || out_fire)
        idx <= idx + 1'b1;
      if (last_in)
        flipped <= t_next_neg;
    end
  end

  // NOTE: the coefficient buffer has no reset; its contents are only read
  // after a full LOAD has overwritten every entry.
  always_ff @(posedge clk) begin
    if (in_fire)
      coef_buf[idx] <= coef_in_c;
  end

  // |t| never exceeds N-1, which fits the signed accumulator.
  always_ff @(posedge clk) begin
    if (!rst)
      assert (corr_t <= T_MAX && corr_t >= -T_MAX);
  end

`ifdef TERNARY_PLUS_VEC_OUT_EN
  logic [2*N-1:0] vec_next;

  // The last coefficient is still on the input bus when the snapshot is
  // taken, and the flip decision is the one being registered this cycle.
  for (genvar g = 0; g < N; g++) begin : g_vec
    coef_t src;
    assign src = (g == N - 1) ? coef_in_c : coef_buf[g];
    assign vec_next[2*g+1:2*g] = (t_next_neg && (g % 2 == 0)) ? coef_neg(src) : src;
  end

  always_ff @(posedge clk) begin
    if (rst) vec_valid <= 1'b0;
    else     vec_valid <= last_in;
  end

  always_ff @(posedge clk) begin
    if (last_in && !rst)
      out_vec <= vec_next;
  end
`endif

endmodule

// File: tb/tb_ternary_plus.sv
// Self-checking bench for ternary_plus: a bench-side model computes the
// correlation and the corrected polynomial, pushes expected coefficients
// into a queue while the stimulus is driven, and each scenario pops and
// compares them as the DUT streams its output.
module tb_ternary_plus;
  import ternary_pkg::*;

  localparam int N = N_COEF;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [1:0]     in_coef = 2'b00;
  logic           in_ready;
  logic           out_valid;
  logic [1:0]     out_coef;
  logic           out_ready = 1'b0;
  logic           out_last;
  logic           flipped;
  logic           busy;
`ifdef TERNARY_PLUS_VEC_OUT_EN
  logic [2*N-1:0] out_vec;
  logic           vec_valid;
  int             vec_pulses = 0;
  logic [2*N-1:0] vec_seen;
`endif

  ternary_plus dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_coef   (in_coef),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_coef  (out_coef),
    .out_ready (out_ready),
    .out_last  (out_last),
    .flipped   (flipped),
    .busy      (busy)
`ifdef TERNARY_PLUS_VEC_OUT_EN
    ,
    .out_vec   (out_vec),
    .vec_valid (vec_valid)
`endif
  );

  always #5 clk = ~clk;

`ifdef TERNARY_PLUS_VEC_OUT_EN
  always @(negedge clk) begin
    if (!rst && vec_valid) begin
      vec_pulses++;
      vec_seen = out_vec;
    end
  end
`endif

  coef_t stim [N];
  coef_t obs_coef [N];
  logic  obs_last [N];
  coef_t exp_q [$];
  bit    exp_flip;
  int    n_vec = 0;
  int    n_miss = 0;
  int    beats, stall_err, irdy_err;
  bit    early_out, busy_seen;

  function automatic int cval(input coef_t c);
    if (c == 2'b01) return 1;
    if (c == 2'b10) return -1;
    return 0;
  endfunction

  // Expected output: computed from scratch off the stimulus array.
  task automatic build_expected();
    int    t;
    coef_t s;
    t = 0;
    for (int i = 1; i < N; i++) t += cval(stim[i-1]) * cval(stim[i]);
    exp_flip = (t < 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      s = stim[i];
      if (s == 2'b11) s = 2'b00;
      if (exp_flip && (i % 2 == 0)) begin
        if (s == 2'b01)      s = 2'b10;
        else if (s == 2'b10) s = 2'b01;
      end
      exp_q.push_back(s);
    end
  endtask

  // Drives stim[0..N-1]; a non-negative abort_at pulses rst instead of that beat.
  task automatic drive_poly(input int abort_at);
    int w;
    bit rdy;
    early_out = 0;
    if (abort_at < 0) build_expected();
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      in_valid = 1'b1;
      in_coef  = stim[i];
      w = 0;
      do begin
        @(negedge clk);
        rdy = in_ready;
        if (out_valid) early_out = 1;
        if (i == 1) busy_seen = busy;
        @(posedge clk); #1;
        w++;
      end while (!rdy && w < 10);
      if (!rdy) begin
        n_vec++; n_miss++;
        $display("FAIL drive_timeout beat %0d: in_ready stayed %b, required 1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_coef  = 2'b00;
  endtask

  // Collects one output polynomial with the given stall percentage.
  task automatic collect(input int stall_pct);
    bit    held, done;
    coef_t held_coef;
    int    cyc;
    beats = 0; stall_err = 0; irdy_err = 0; held = 0; done = 0; cyc = 0;
    while (!done && beats < N && cyc < 20 * N) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (out_valid) begin
        if (held && out_coef !== held_coef) stall_err++;
        if (in_ready !== 1'b0) irdy_err++;
        if (out_ready) begin
          obs_coef[beats] = out_coef;
          obs_last[beats] = out_last;
          beats++;
          held = 0;
          if (out_last) done = 1;
        end else begin
          held = 1;
          held_coef = out_coef;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= 20 * N) begin
      n_vec++; n_miss++;
      $display("FAIL collect_timeout: %0d beats after %0d cycles, required %0d", beats, cyc, N);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1)  begin n_miss++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_last !== 1'b0)  begin n_miss++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_vec++; if (flipped !== 1'b0)   begin n_miss++; $display("FAIL reset_flipped: got %b want 0", flipped); end
    n_vec++; if (busy !== 1'b0)      begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    coef_t e;
    for (int i = 0; i < N; i++) stim[i] = COEF_POS;
    drive_poly(-1);
    n_vec++; if (early_out !== 1'b0) begin n_miss++; $display("FAIL ones_early_out: got %b want 0", early_out); end
    n_vec++; if (busy_seen !== 1'b1) begin n_miss++; $display("FAIL ones_busy_load: got %b want 1", busy_seen); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL ones_latency: out_valid %b want 1", out_valid); end
    @(posedge clk); #1;
    collect(0);
    n_vec++; if (beats !== N) begin n_miss++; $display("FAIL ones_beats: got %0d want %0d", beats, N); end
    n_vec++; if (flipped !== exp_flip) begin n_miss++; $display("FAIL ones_flipped: got %b want %b", flipped, exp_flip); end
    for (int i = 0; i < beats; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (obs_coef[i] !== e) begin n_miss++; $display("FAIL ones_coef[%0d]: got %b want %b", i, obs_coef[i], e); end
      n_vec++; if (obs_last[i] !== (i == N - 1)) begin n_miss++; $display("FAIL ones_last[%0d]: got %b want %b", i, obs_last[i], (i == N - 1)); end
    end
  endtask

  task automatic test_zero_corr();
    coef_t e;
    for (int i = 0; i < N; i++) stim[i] = (i % 50 == 7) ? 2'b11 : COEF_ZERO;
    stim[0] = COEF_POS; stim[1] = COEF_NEG; stim[2] = COEF_NEG;
    drive_poly(-1);
    collect(0);
    n_vec++; if (beats !== N) begin n_miss++; $display("FAIL zero_beats: got %0d want %0d", beats, N); end
    n_vec++; if (flipped !== 1'b0) begin n_miss++; $display("FAIL zero_flipped: got %b want 0", flipped); end
    for (int i = 0; i < beats; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (obs_coef[i] !== e) begin n_miss++; $display("FAIL zero_coef[%0d]: got %b want %b", i, obs_coef[i], e); end
    end
  endtask

  task automatic test_pattern_pm0();
    coef_t e;
    for (int i = 0; i < N; i++)
      stim[i] = (i % 3 == 0) ? COEF_POS : ((i % 3 == 1) ? COEF_NEG : COEF_ZERO);
    drive_poly(-1);
    collect(0);
    n_vec++; if (beats !== N) begin n_miss++; $display("FAIL pm0_beats: got %0d want %0d", beats, N); end
    n_vec++; if (flipped !== 1'b1) begin n_miss++; $display("FAIL pm0_flipped: got %b want 1", flipped); end
    n_vec++; if (obs_coef[3] !== COEF_POS) begin n_miss++; $display("FAIL pm0_idx3: got %b want 01", obs_coef[3]); end
    for (int i = 0; i < beats; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (obs_coef[i] !== e) begin n_miss++; $display("FAIL pm0_coef[%0d]: got %b want %b", i, obs_coef[i], e); end
    end
  endtask

  task automatic test_stall();
    coef_t e;
    for (int i = 0; i < N; i++) stim[i] = coef_t'($urandom_range(3));
    drive_poly(-1);
    collect(30);
    n_vec++; if (beats !== N) begin n_miss++; $display("FAIL stall_beats: got %0d want %0d", beats, N); end
    n_vec++; if (stall_err !== 0) begin n_miss++; $display("FAIL stall_stable: %0d changes while stalled, want 0", stall_err); end
    n_vec++; if (irdy_err !== 0) begin n_miss++; $display("FAIL stall_in_ready: %0d cycles high in EMIT, want 0", irdy_err); end
    n_vec++; if (flipped !== exp_flip) begin n_miss++; $display("FAIL stall_flipped: got %b want %b", flipped, exp_flip); end
    for (int i = 0; i < beats; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (obs_coef[i] !== e) begin n_miss++; $display("FAIL stall_coef[%0d]: got %b want %b", i, obs_coef[i], e); end
      n_vec++; if (obs_last[i] !== (i == N - 1)) begin n_miss++; $display("FAIL stall_last[%0d]: got %b want %b", i, obs_last[i], (i == N - 1)); end
    end
  endtask

  task automatic test_alternating();
    coef_t e;
    for (int i = 0; i < N; i++) stim[i] = (i % 2 == 0) ? COEF_POS : COEF_NEG;
    drive_poly(-1);
    collect(0);
    n_vec++; if (beats !== N) begin n_miss++; $display("FAIL alt_beats: got %0d want %0d", beats, N); end
    n_vec++; if (flipped !== 1'b1) begin n_miss++; $display("FAIL alt_flipped: got %b want 1", flipped); end
    for (int i = 0; i < beats; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (obs_coef[i] !== e) begin n_miss++; $display("FAIL alt_coef[%0d]: got %b want %b", i, obs_coef[i], e); end
    end
    @(negedge clk);
    n_vec++; if (flipped !== 1'b1) begin n_miss++; $display("FAIL alt_flipped_hold: got %b want 1", flipped); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL alt_back_to_load: in_ready %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    coef_t e;
    for (int i = 0; i < N; i++) stim[i] = (i % 2 == 0) ? COEF_NEG : COEF_POS;
`ifdef TERNARY_PLUS_VEC_OUT_EN
    vec_pulses = 0;
`endif
    drive_poly(350);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0)      begin n_miss++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_vec++; if (flipped !== 1'b0)   begin n_miss++; $display("FAIL abort_flipped: got %b want 0", flipped); end
    n_vec++; if (in_ready !== 1'b1)  begin n_miss++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) stim[i] = COEF_ZERO;
    drive_poly(-1);
    n_vec++; if (early_out !== 1'b0) begin n_miss++; $display("FAIL abort_early_out: got %b want 0", early_out); end
    collect(0);
    n_vec++; if (beats !== N) begin n_miss++; $display("FAIL abort_beats: got %0d want %0d", beats, N); end
    n_vec++; if (flipped !== 1'b0) begin n_miss++; $display("FAIL abort_zero_flipped: got %b want 0", flipped); end
    for (int i = 0; i < beats; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (obs_coef[i] !== e) begin n_miss++; $display("FAIL abort_coef[%0d]: got %b want %b", i, obs_coef[i], e); end
    end
`ifdef TERNARY_PLUS_VEC_OUT_EN
    n_vec++; if (vec_pulses !== 1) begin n_miss++; $display("FAIL vec_pulses: got %0d want 1", vec_pulses); end
    n_vec++; if (vec_seen !== '0) begin n_miss++; $display("FAIL vec_zero: out_vec nonzero, want all zero"); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_all_ones();
    test_zero_corr();
    test_pattern_pm0();
    test_stall();
    test_alternating();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
